// File: rtl/wb_retire_queue_pkg.sv
// Entry layout for the writeback retire queue, packed LSB-first as
// {halt, wr_csr, wcsrno, wr_reg, wregno, regval, inst, pc}.
package wb_retire_queue_pkg;

  function automatic int wb_entry_width(input int d, input int i, input int r, input int c);
    return 2*d + i + r + c + 3;
  endfunction

  function automatic int wb_off_inst(input int d);
    return d;
  endfunction

  function automatic int wb_off_regval(input int d, input int i);
    return d + i;
  endfunction

  function automatic int wb_off_wregno(input int d, input int i);
    return 2*d + i;
  endfunction

  function automatic int wb_off_wr_reg(input int d, input int i, input int r);
    return 2*d + i + r;
  endfunction

  function automatic int wb_off_wcsrno(input int d, input int i, input int r);
    return 2*d + i + r + 1;
  endfunction

  function automatic int wb_off_wr_csr(input int d, input int i, input int r, input int c);
    return 2*d + i + r + c + 1;
  endfunction

  function automatic int wb_off_halt(input int d, input int i, input int r, input int c);
    return 2*d + i + r + c + 2;
  endfunction

endpackage

// File: rtl/wb_entry_fifo.sv
// Pending-entry storage with wrap-bit pointers; exposes every slot ordered oldest-first.
// Push/pop take effect at the clock edge; caller guarantees no push when full, no pop when empty.
module wb_entry_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic [WIDTH-1:0]                    push_dat,
  input  logic                                pop,
  output logic                                empty,
  output logic                                full,
  output logic [$clog2(DEPTH):0]              count,
  output logic [DEPTH-1:0]                    ent_vld,
  output logic [DEPTH-1:0][WIDTH-1:0]         ent_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload needs no reset: nothing downstream looks at a slot outside the valid window.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign count = wr_ptr_q - rd_ptr_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    logic [AW-1:0] idx;
    assign idx        = rd_ptr_q[AW-1:0] + AW'(k);
    assign ent_dat[k] = mem_q[idx];
    assign ent_vld[k] = ((AW+1)'(k) < count);
  end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order writeback queue: retires one entry per cycle into GPR/CSR files, forwards pending values.
// First write one cycle after push; stalls on rf_ready; in_ready is registered !full && !halted.
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int INSTBITS  = 32,
  parameter int REGNOBITS = 5,
  parameter int CSRNOBITS = 12,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DBITS-1:0]     in_pc,
  input  logic [INSTBITS-1:0]  in_inst,
  input  logic                 in_wr_reg,
  input  logic [REGNOBITS-1:0] in_wregno,
  input  logic                 in_wr_csr,
  input  logic [CSRNOBITS-1:0] in_wcsrno,
  input  logic [DBITS-1:0]     in_regval,
  input  logic                 in_halt,
  input  logic                 rf_ready,
  output logic                 rf_we,
  output logic [REGNOBITS-1:0] rf_wregno,
  output logic                 csr_we,
  output logic [CSRNOBITS-1:0] csr_wcsrno,
  output logic [DBITS-1:0]     wdata,
  input  logic [REGNOBITS-1:0] q1_regno,
  output logic                 q1_hit,
  output logic [DBITS-1:0]     q1_data,
  input  logic [REGNOBITS-1:0] q2_regno,
  output logic                 q2_hit,
  output logic [DBITS-1:0]     q2_data,
  output logic [DBITS-1:0]     retire_count,
  output logic [DBITS-1:0]     last_pc,
  output logic [INSTBITS-1:0]  last_inst,
  output logic                 halted
);
  localparam int EW       = wb_entry_width(DBITS, INSTBITS, REGNOBITS, CSRNOBITS);
  localparam int O_INST   = wb_off_inst(DBITS);
  localparam int O_REGVAL = wb_off_regval(DBITS, INSTBITS);
  localparam int O_WREGNO = wb_off_wregno(DBITS, INSTBITS);
  localparam int O_WR_REG = wb_off_wr_reg(DBITS, INSTBITS, REGNOBITS);
  localparam int O_WCSRNO = wb_off_wcsrno(DBITS, INSTBITS, REGNOBITS);
  localparam int O_WR_CSR = wb_off_wr_csr(DBITS, INSTBITS, REGNOBITS, CSRNOBITS);
  localparam int O_HALT   = wb_off_halt(DBITS, INSTBITS, REGNOBITS, CSRNOBITS);
  localparam int PW       = $clog2(DEPTH);

  logic [EW-1:0]             in_dat;
  logic [DEPTH-1:0][EW-1:0]  ent_dat;
  logic [DEPTH-1:0]          ent_vld;
  logic [PW:0]               count, count_nxt;
  logic                      empty, full, push, pop;

  logic                      in_ready_q, in_ready_d;
  logic                      halted_q, halted_d;
  logic [DBITS-1:0]          retire_count_q, retire_count_d;
  logic [DBITS-1:0]          last_pc_q, last_pc_d;
  logic [INSTBITS-1:0]       last_inst_q, last_inst_d;

  logic [DBITS-1:0]          head_pc, head_regval;
  logic [INSTBITS-1:0]       head_inst;
  logic [REGNOBITS-1:0]      head_wregno;
  logic [CSRNOBITS-1:0]      head_wcsrno;
  logic                      head_wr_reg, head_wr_csr, head_halt;

  assign in_dat = {in_halt, in_wr_csr, in_wcsrno, in_wr_reg, in_wregno, in_regval, in_inst, in_pc};
  assign push   = in_valid && in_ready_q && !full;
  // A retired halt freezes the head so the entries behind it never write.
  assign pop    = !empty && rf_ready && !halted_q;

  wb_entry_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (in_dat),
    .pop      (pop),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ent_vld  (ent_vld),
    .ent_dat  (ent_dat)
  );

  assign head_pc     = ent_dat[0][DBITS-1:0];
  assign head_inst   = ent_dat[0][O_INST +: INSTBITS];
  assign head_regval = ent_dat[0][O_REGVAL +: DBITS];
  assign head_wregno = ent_dat[0][O_WREGNO +: REGNOBITS];
  assign head_wr_reg = ent_dat[0][O_WR_REG];
  assign head_wcsrno = ent_dat[0][O_WCSRNO +: CSRNOBITS];
  assign head_wr_csr = ent_dat[0][O_WR_CSR];
  assign head_halt   = ent_dat[0][O_HALT];

  always_comb begin
    count_nxt      = count + (PW+1)'(push) - (PW+1)'(pop);
    halted_d       = halted_q | (pop & head_halt);
    in_ready_d     = (count_nxt != (PW+1)'(DEPTH)) && !halted_d;
    retire_count_d = retire_count_q;
    last_pc_d      = last_pc_q;
    last_inst_d    = last_inst_q;
    if (pop) begin
      retire_count_d = retire_count_q + DBITS'(1);
      last_pc_d      = head_pc;
      last_inst_d    = head_inst;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q     <= 1'b1;
      halted_q       <= 1'b0;
      retire_count_q <= '0;
      last_pc_q      <= '0;
      last_inst_q    <= '0;
    end else begin
      in_ready_q     <= in_ready_d;
      halted_q       <= halted_d;
      retire_count_q <= retire_count_d;
      last_pc_q      <= last_pc_d;
      last_inst_q    <= last_inst_d;
    end
  end

  assign rf_we      = pop && head_wr_reg && (head_wregno != '0);
  assign csr_we     = pop && head_wr_csr;
  assign rf_wregno  = empty ? '0 : head_wregno;
  assign csr_wcsrno = empty ? '0 : head_wcsrno;
  assign wdata      = empty ? '0 : head_regval;

  assign in_ready     = in_ready_q;
  assign halted       = halted_q;
  assign retire_count = retire_count_q;
  assign last_pc      = last_pc_q;
  assign last_inst    = last_inst_q;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[k] && ent_dat[k][O_WR_REG] && (q1_regno != '0) &&
          (ent_dat[k][O_WREGNO +: REGNOBITS] == q1_regno)) begin
        q1_hit  = 1'b1;
        q1_data = ent_dat[k][O_REGVAL +: DBITS];
      end
      if (ent_vld[k] && ent_dat[k][O_WR_REG] && (q2_regno != '0) &&
          (ent_dat[k][O_WREGNO +: REGNOBITS] == q2_regno)) begin
        q2_hit  = 1'b1;
        q2_data = ent_dat[k][O_REGVAL +: DBITS];
      end
    end
  end

endmodule
